// File: rtl/divisor_pkg.sv
// Shared types and helpers for the parametrised restoring divider.
// The optional signed build is enabled by defining DIV_SIGNED_EN.
package divisor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int DIV_MAX_WIDTH = 32;

   // Iteration counter width; one spare code keeps WIDTH-1 representable for every legal WIDTH.
   function automatic int div_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/divisor_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract B, restore on borrow.
module divisor_step #(
   parameter int WIDTH = 7
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   logic           ge;

   // rem < B before the shift, so the shifted value needs one extra bit but the result fits WIDTH.
   assign rem_sh   = {rem, quo[WIDTH-1]};
   assign ge       = (rem_sh >= {1'b0, b});
   assign rem_next = ge ? WIDTH'(rem_sh - {1'b0, b}) : rem_sh[WIDTH-1:0];
   assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/divisor_restoring_nbits.sv
// Multi-cycle restoring divider Q = A/B, R = A%B, one quotient bit per clock.
// Define DIV_SIGNED_EN to add the signed_mode port and the FIX sign-correction state.
module divisor_restoring_nbits
   import divisor_pkg::*;
#(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
`ifdef DIV_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [1:0]       dbg_state
);

   // Handshake: start is sampled only at a posedge in IDLE or DONE; an accepted start captures
   // A_in/B_in and drops done. busy is high in CALC/FIX, where start is ignored. done stays high
   // with stable Q/R/div_by_zero until the next accepted start or reset.

   localparam int             CW       = div_cnt_w(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   div_state_t       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [CW-1:0]    cnt;

`ifdef DIV_SIGNED_EN
   logic a_neg;
   logic b_neg;
   logic neg_q;
   logic neg_r;

   assign a_neg = signed_mode & A_in[WIDTH-1];
   assign b_neg = signed_mode & B_in[WIDTH-1];
   // Most-negative operands map onto themselves, which is the correct unsigned magnitude.
   assign a_mag = a_neg ? -A_in : A_in;
   assign b_mag = b_neg ? -B_in : B_in;
`else
   assign a_mag = A_in;
   assign b_mag = B_in;
`endif

   divisor_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .b        (b_reg),
      .rem_next (rem_nx),
      .quo_next (quo_nx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         rem         <= '0;
         quo         <= '0;
         cnt         <= '0;
         Q           <= '0;
         R           <= '0;
         div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_reg       <= A_in;
                  b_reg       <= b_mag;
                  rem         <= '0;
                  quo         <= a_mag;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                  neg_q       <= a_neg ^ b_neg;
                  neg_r       <= a_neg;
`endif
                  state       <= CALC;
               end
            end
            CALC: begin
               if (b_reg == '0) begin
                  Q           <= '1;
                  R           <= a_reg;
                  div_by_zero <= 1'b1;
                  state       <= DONE;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + CW'(1);
                  if (cnt == CNT_LAST) begin
`ifdef DIV_SIGNED_EN
                     state <= FIX;
`else
                     Q     <= quo_nx;
                     R     <= rem_nx;
                     state <= DONE;
`endif
                  end
               end
            end
`ifdef DIV_SIGNED_EN
            FIX: begin
               Q     <= neg_q ? -quo : quo;
               R     <= neg_r ? -rem : rem;
               state <= DONE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state == CALC) || (state == FIX);
   assign done      = (state == DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_divisor_restoring_nbits.sv
// Directed-vector bench for divisor_restoring_nbits (WIDTH=7 and WIDTH=16, plus WIDTH=8 signed
// when DIV_SIGNED_EN is defined).
module tb_divisor_restoring_nbits;

`ifdef DIV_SIGNED_EN
   localparam int FIX_EXTRA = 1;
`else
   localparam int FIX_EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       start7 = 1'b0;
   logic [6:0] a7 = '0, b7 = '0, q7, r7;
   logic       busy7, done7, dz7;
   logic [1:0] st7;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, q16, r16;
   logic        busy16, done16, dz16;
   logic [1:0]  st16;

   int n_pass  = 0;
   int n_total = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
      $fatal(1, "timeout");
   end

   divisor_restoring_nbits #(.WIDTH(7)) u_dut7 (
      .clk         (clk),
      .rst         (rst_n),
      .start       (start7),
      .A_in        (a7),
      .B_in        (b7),
`ifdef DIV_SIGNED_EN
      .signed_mode (1'b0),
`endif
      .Q           (q7),
      .R           (r7),
      .busy        (busy7),
      .done        (done7),
      .div_by_zero (dz7),
      .dbg_state   (st7)
   );

   divisor_restoring_nbits #(.WIDTH(16)) u_dut16 (
      .clk         (clk),
      .rst         (rst_n),
      .start       (start16),
      .A_in        (a16),
      .B_in        (b16),
`ifdef DIV_SIGNED_EN
      .signed_mode (1'b0),
`endif
      .Q           (q16),
      .R           (r16),
      .busy        (busy16),
      .done        (done16),
      .div_by_zero (dz16),
      .dbg_state   (st16)
   );

`ifdef DIV_SIGNED_EN
   logic       start8 = 1'b0, sm8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, q8, r8;
   logic       busy8, done8, dz8;
   logic [1:0] st8;

   divisor_restoring_nbits #(.WIDTH(8)) u_dut8 (
      .clk         (clk),
      .rst         (rst_n),
      .start       (start8),
      .A_in        (a8),
      .B_in        (b8),
      .signed_mode (sm8),
      .Q           (q8),
      .R           (r8),
      .busy        (busy8),
      .done        (done8),
      .div_by_zero (dz8),
      .dbg_state   (st8)
   );
`endif

   // ---------------- driver tasks ----------------
   // Start is presented for exactly one posedge; returns at the negedge after the accepted edge.
   task automatic go7(input logic [6:0] a, input logic [6:0] b);
      @(negedge clk);
      a7 = a; b7 = b; start7 = 1'b1;
      @(negedge clk);
      start7 = 1'b0;
   endtask

   task automatic wait_done7(output int n);
      n = 0;
      while (done7 !== 1'b1 && n < 60) begin
         @(posedge clk); n++; @(negedge clk);
      end
   endtask

   task automatic go16(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      a16 = a; b16 = b; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
   endtask

   task automatic wait_done16(output int n);
      n = 0;
      while (done16 !== 1'b1 && n < 60) begin
         @(posedge clk); n++; @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({q7, r7, busy7, done7, dz7, st7} !== '0) begin
         $display("FAIL reset_w7: got Q=%0d R=%0d busy=%b done=%b dz=%b st=%0d, required all 0",
                  q7, r7, busy7, done7, dz7, st7);
      end else n_pass++;
      n_total++;
      if ({q16, r16, busy16, done16, dz16, st16} !== '0) begin
         $display("FAIL reset_w16: got Q=%0d R=%0d busy=%b done=%b dz=%b, required all 0",
                  q16, r16, busy16, done16, dz16);
      end else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_unsigned7();
      logic [6:0] va [6] = '{7'd127, 7'd85, 7'd64, 7'd123, 7'd100, 7'd99};
      logic [6:0] vb [6] = '{7'd7,   7'd5,  7'd8,  7'd9,   7'd13,  7'd10};
      logic [6:0] eq [6] = '{7'd18,  7'd17, 7'd8,  7'd13,  7'd7,   7'd9};
      logic [6:0] er [6] = '{7'd1,   7'd0,  7'd0,  7'd6,   7'd9,   7'd9};
      int n;
      for (int i = 0; i < 6; i++) begin
         go7(va[i], vb[i]);
         wait_done7(n);
         n_total++;
         if (n !== 7 + FIX_EXTRA || q7 !== eq[i] || r7 !== er[i] || dz7 !== 1'b0) begin
            $display("FAIL div7_%0d_%0d: got Q=%0d R=%0d dz=%b lat=%0d, required Q=%0d R=%0d dz=0 lat=%0d",
                     va[i], vb[i], q7, r7, dz7, n, eq[i], er[i], 7 + FIX_EXTRA);
         end else n_pass++;
      end
      n_total++;
      if (st7 !== 2'd3 || busy7 !== 1'b0) begin
         $display("FAIL done_state: got st=%0d busy=%b, required st=3 busy=0", st7, busy7);
      end else n_pass++;
   endtask

   task automatic test_div_by_zero();
      int n;
      go7(7'd50, 7'd0);
      wait_done7(n);
      n_total++;
      if (n !== 1 || q7 !== 7'd127 || r7 !== 7'd50 || dz7 !== 1'b1) begin
         $display("FAIL div_zero: got Q=%0d R=%0d dz=%b lat=%0d, required Q=127 R=50 dz=1 lat=1",
                  q7, r7, dz7, n);
      end else n_pass++;
      go7(7'd50, 7'd5);
      n_total++;
      if (dz7 !== 1'b0 || done7 !== 1'b0 || q7 !== 7'd127) begin
         $display("FAIL dz_clear_on_start: got dz=%b done=%b Q=%0d, required dz=0 done=0 Q=127 (held)",
                  dz7, done7, q7);
      end else n_pass++;
      wait_done7(n);
      n_total++;
      if (q7 !== 7'd10 || r7 !== 7'd0 || dz7 !== 1'b0 || n !== 7 + FIX_EXTRA) begin
         $display("FAIL after_zero: got Q=%0d R=%0d dz=%b lat=%0d, required Q=10 R=0 dz=0 lat=%0d",
                  q7, r7, dz7, n, 7 + FIX_EXTRA);
      end else n_pass++;
   endtask

   task automatic test_busy_reject();
      int n, bc;
      go7(7'd127, 7'd7);
      n = 0; bc = 0;
      while (done7 !== 1'b1 && n < 60) begin
         if (busy7) bc++;
         if (n == 2) begin
            start7 = 1'b1; a7 = 7'd9; b7 = 7'd3;
         end else start7 = 1'b0;
         @(posedge clk); n++; @(negedge clk);
      end
      start7 = 1'b0;
      n_total++;
      if (q7 !== 7'd18 || r7 !== 7'd1 || n !== 7 + FIX_EXTRA) begin
         $display("FAIL busy_reject_result: got Q=%0d R=%0d lat=%0d, required Q=18 R=1 lat=%0d",
                  q7, r7, n, 7 + FIX_EXTRA);
      end else n_pass++;
      n_total++;
      if (bc !== 7 + FIX_EXTRA) begin
         $display("FAIL busy_cycles: got %0d, required %0d", bc, 7 + FIX_EXTRA);
      end else n_pass++;
      repeat (3) @(negedge clk);
      n_total++;
      if (done7 !== 1'b1 || busy7 !== 1'b0 || q7 !== 7'd18 || r7 !== 7'd1) begin
         $display("FAIL done_hold: got done=%b busy=%b Q=%0d R=%0d, required done=1 busy=0 Q=18 R=1",
                  done7, busy7, q7, r7);
      end else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int n;
      go7(7'd100, 7'd13);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({q7, r7, busy7, done7, dz7, st7} !== '0) begin
         $display("FAIL reset_mid_op: got Q=%0d R=%0d busy=%b done=%b dz=%b st=%0d, required all 0",
                  q7, r7, busy7, done7, dz7, st7);
      end else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      n_total++;
      if (done7 !== 1'b0 || busy7 !== 1'b0 || q7 !== 7'd0) begin
         $display("FAIL no_late_completion: got done=%b busy=%b Q=%0d, required done=0 busy=0 Q=0",
                  done7, busy7, q7);
      end else n_pass++;
      go7(7'd99, 7'd10);
      wait_done7(n);
      n_total++;
      if (q7 !== 7'd9 || r7 !== 7'd9 || n !== 7 + FIX_EXTRA) begin
         $display("FAIL after_reset: got Q=%0d R=%0d lat=%0d, required Q=9 R=9 lat=%0d",
                  q7, r7, n, 7 + FIX_EXTRA);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      a7 = 7'd85; b7 = 7'd5; start7 = 1'b1;
      @(negedge clk);
      a7 = 7'd64; b7 = 7'd8;
      wait_done7(n);
      n_total++;
      if (q7 !== 7'd17 || r7 !== 7'd0 || n !== 7 + FIX_EXTRA) begin
         $display("FAIL b2b_first: got Q=%0d R=%0d lat=%0d, required Q=17 R=0 lat=%0d",
                  q7, r7, n, 7 + FIX_EXTRA);
      end else n_pass++;
      @(negedge clk);
      start7 = 1'b0;
      n_total++;
      if (done7 !== 1'b0 || busy7 !== 1'b1) begin
         $display("FAIL b2b_restart: got done=%b busy=%b, required done=0 busy=1", done7, busy7);
      end else n_pass++;
      wait_done7(n);
      n_total++;
      if (q7 !== 7'd8 || r7 !== 7'd0 || n !== 7 + FIX_EXTRA) begin
         $display("FAIL b2b_second: got Q=%0d R=%0d lat=%0d, required Q=8 R=0 lat=%0d",
                  q7, r7, n, 7 + FIX_EXTRA);
      end else n_pass++;
   endtask

   task automatic test_width16();
      logic [15:0] va [4] = '{16'd65535, 16'd1000, 16'd5, 16'd7};
      logic [15:0] vb [4] = '{16'd255,   16'd1000, 16'd9, 16'd1};
      logic [15:0] eq [4] = '{16'd257,   16'd1,    16'd0, 16'd7};
      logic [15:0] er [4] = '{16'd0,     16'd0,    16'd5, 16'd0};
      int n;
      for (int i = 0; i < 4; i++) begin
         go16(va[i], vb[i]);
         wait_done16(n);
         n_total++;
         if (n !== 16 + FIX_EXTRA || q16 !== eq[i] || r16 !== er[i]) begin
            $display("FAIL div16_%0d_%0d: got Q=%0d R=%0d lat=%0d, required Q=%0d R=%0d lat=%0d",
                     va[i], vb[i], q16, r16, n, eq[i], er[i], 16 + FIX_EXTRA);
         end else n_pass++;
      end
   endtask

`ifdef DIV_SIGNED_EN
   task automatic test_signed();
      logic [7:0] va [4] = '{8'h9C, 8'd100, 8'h80, 8'h9C};
      logic [7:0] vb [4] = '{8'd13, 8'hF3,  8'hFF, 8'd13};
      logic       vs [4] = '{1'b1,  1'b1,   1'b1,  1'b0};
      logic [7:0] eq [4] = '{8'hF9, 8'hF9,  8'h80, 8'd12};
      logic [7:0] er [4] = '{8'hF7, 8'd9,   8'h00, 8'd0};
      int n;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a8 = va[i]; b8 = vb[i]; sm8 = vs[i]; start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         n = 0;
         while (done8 !== 1'b1 && n < 60) begin
            @(posedge clk); n++; @(negedge clk);
         end
         n_total++;
         if (n !== 9 || q8 !== eq[i] || r8 !== er[i] || dz8 !== 1'b0) begin
            $display("FAIL signed_%0d: got Q=%h R=%h dz=%b lat=%0d, required Q=%h R=%h dz=0 lat=9",
                     i, q8, r8, dz8, n, eq[i], er[i]);
         end else n_pass++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_unsigned7();
      test_div_by_zero();
      test_busy_reject();
      test_reset_mid_op();
      test_back_to_back();
      test_width16();
`ifdef DIV_SIGNED_EN
      test_signed();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
